// File: rtl/mem_responder.sv
// Fixed-latency memory responder with one outstanding read and a backdoor preload port.
// Optional macro MEM_RESPONDER_ADDR_ERR_EN adds axi_err_o for misaligned or out-of-range addresses.
module mem_responder #(
    parameter int unsigned total_width     = 32,
    parameter int unsigned word_addr_width = 10,
    parameter int unsigned LATENCY         = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       axi_start_i,
    input  logic [total_width-1:0]     axi_address_i,
    output logic                       axi_rdy_o,
    output logic [total_width-1:0]     axi_data_o,
    input  logic                       load_we_i,
    input  logic [word_addr_width-1:0] load_addr_i,
    input  logic [total_width-1:0]     load_data_i
`ifdef MEM_RESPONDER_ADDR_ERR_EN
    ,
    output logic                       axi_err_o
`endif
);

    localparam int unsigned DEPTH = 1 << word_addr_width;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        RESPOND
    } state_t;

    state_t                     r_state;
    state_t                     w_next_state;
    logic [CNT_W-1:0]           r_cnt;
    logic [total_width-1:0]     r_addr;
    logic [total_width-1:0]     r_data;
    logic                       r_rdy;
    logic                       w_accept;
    logic                       w_fire;
    logic                       w_addr_bad;
    logic [word_addr_width-1:0] w_rd_idx;
    logic [total_width-1:0]     r_mem [DEPTH];

    // Byte address -> word index; upper bits drop out so the index wraps modulo depth.
    assign w_rd_idx = r_addr[word_addr_width+1:2];

`ifdef MEM_RESPONDER_ADDR_ERR_EN
    logic r_err;

    assign w_addr_bad = (r_addr[1:0] != 2'b00) ||
                        ((r_addr >> (word_addr_width + 2)) != '0);
    assign axi_err_o  = r_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_fire && w_addr_bad;
        end
    end
`else
    logic w_unused_addr;

    assign w_addr_bad    = 1'b0;
    assign w_unused_addr = ^{r_addr[1:0], r_addr >> (word_addr_width + 2)};
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and request strobes; starts outside IDLE are dropped, not queued.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_fire       = 1'b0;
        case (r_state)
            IDLE: begin
                if (axi_start_i) begin
                    w_accept     = 1'b1;
                    w_next_state = DELAY;
                end
            end
            DELAY: begin
                if (r_cnt == CNT_LAST) begin
                    w_fire       = 1'b1;
                    w_next_state = RESPOND;
                end
            end
            RESPOND: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Request datapath; the array read sees contents from before this edge's load write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt  <= '0;
            r_addr <= '0;
            r_rdy  <= 1'b0;
            r_data <= '0;
        end else begin
            r_rdy <= w_fire;
            if (w_accept) begin
                r_addr <= axi_address_i;
                r_cnt  <= '0;
            end else if (r_state == DELAY) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_fire) begin
                r_data <= w_addr_bad ? '0 : r_mem[w_rd_idx];
            end
        end
    end

    // Backdoor preload; the array itself is never cleared.
    always_ff @(posedge clk_i) begin
        if (load_we_i && !rst_i) begin
            r_mem[load_addr_i] <= load_data_i;
        end
    end

    assign axi_rdy_o  = r_rdy;
    assign axi_data_o = r_data;

endmodule
